// File: rtl/carry_select_subtractor_pipelined_32bits.sv
// Two-stage pipelined carry-select subtractor: D = A - B - Bin, computed as A + ~B + ~Bin.
// The stage-1 register sits at a block boundary; stage 2 resolves the high carry-select chain.
module carry_select_subtractor_pipelined_32bits #(
  parameter int unsigned WIDTH                      = 32,
  parameter int unsigned BLOCK_AMOUNT               = 5,
  parameter int unsigned BLOCKS [BLOCK_AMOUNT]      = '{4, 10, 16, 24, 32},
  parameter int unsigned PIPE_CUT                   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             Z
);

  localparam int unsigned B0_W    = BLOCKS[0];
  localparam int unsigned CUT_BIT = BLOCKS[PIPE_CUT];
  localparam int unsigned HI_W    = WIDTH - CUT_BIT;
  localparam int unsigned NUM_HI  = BLOCK_AMOUNT - 1 - PIPE_CUT;

  // Parameter sanity: partition must tile the word and the cut must leave at least one high block
  generate
    if (BLOCKS[BLOCK_AMOUNT-1] != WIDTH) begin : g_err_width
      $error("BLOCKS[BLOCK_AMOUNT-1] must equal WIDTH");
    end
    if (PIPE_CUT >= BLOCK_AMOUNT - 1) begin : g_err_cut
      $error("PIPE_CUT must be below BLOCK_AMOUNT-1");
    end
    if (BLOCKS[0] == 0) begin : g_err_first
      $error("BLOCKS must be strictly increasing from a nonzero first block");
    end
    for (genvar k = 1; k < BLOCK_AMOUNT; k++) begin : g_chk
      if (BLOCKS[k] <= BLOCKS[k-1]) begin : g_err_order
        $error("BLOCKS must be strictly increasing");
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: inverted subtrahend, ripple block 0, dual-sum blocks
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]  b_inv;
  logic              cin;
  logic [B0_W-1:0]   r0_sum;
  logic              r0_c;
  logic [CUT_BIT-1:0] lo_diff;
  logic [PIPE_CUT:0] cy_lo;
  logic [HI_W-1:0]   hi_sum0;
  logic [HI_W-1:0]   hi_sum1;
  logic [NUM_HI-1:0] hi_c0;
  logic [NUM_HI-1:0] hi_c1;

  assign b_inv = ~B;
  assign cin   = ~Bin;

  always_comb begin
    logic c;
    c      = cin;
    r0_sum = '0;
    for (int unsigned i = 0; i < B0_W; i++) begin
      r0_sum[i] = A[i] ^ b_inv[i] ^ c;
      c         = (A[i] & b_inv[i]) | (c & (A[i] ^ b_inv[i]));
    end
    r0_c = c;
  end

  assign lo_diff[B0_W-1:0] = r0_sum;
  assign cy_lo[0]          = r0_c;

  // Each upper block precomputes carry-in 0 and carry-in 1 results
  generate
    for (genvar k = 1; k < BLOCK_AMOUNT; k++) begin : g_blk
      localparam int unsigned LO = BLOCKS[k-1];
      localparam int unsigned W  = BLOCKS[k] - BLOCKS[k-1];
      localparam int unsigned WP = W + 1;
      logic [W:0] t0;
      logic [W:0] t1;

      assign t0 = WP'(A[LO+:W]) + WP'(b_inv[LO+:W]);
      assign t1 = WP'(A[LO+:W]) + WP'(b_inv[LO+:W]) + WP'(1'b1);

      if (k <= PIPE_CUT) begin : g_lo
        assign cy_lo[k]      = cy_lo[k-1] ? t1[W] : t0[W];
        assign lo_diff[LO+:W] = cy_lo[k-1] ? t1[W-1:0] : t0[W-1:0];
      end else begin : g_hi
        localparam int unsigned J   = k - PIPE_CUT - 1;
        localparam int unsigned OFF = LO - CUT_BIT;
        assign hi_sum0[OFF+:W] = t0[W-1:0];
        assign hi_sum1[OFF+:W] = t1[W-1:0];
        assign hi_c0[J]        = t0[W];
        assign hi_c1[J]        = t1[W];
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic               s1_v_q,      s1_v_d;
  logic [CUT_BIT-1:0] s1_lo_q,     s1_lo_d;
  logic               s1_cut_c_q,  s1_cut_c_d;
  logic [HI_W-1:0]    s1_sum0_q,   s1_sum0_d;
  logic [HI_W-1:0]    s1_sum1_q,   s1_sum1_d;
  logic [NUM_HI-1:0]  s1_c0_q,     s1_c0_d;
  logic [NUM_HI-1:0]  s1_c1_q,     s1_c1_d;
  logic               s1_a_msb_q,  s1_a_msb_d;
  logic               s1_b_msb_q,  s1_b_msb_d;

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   d_q,         d_d;
  logic               bout_q,      bout_d;
  logic               v_q,         v_d;
  logic               z_q,         z_d;

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: select chain from the registered cut carry
  // ---------------------------------------------------------------------------
  logic [NUM_HI-1:0] hi_cy;
  logic [HI_W-1:0]   hi_diff;
  logic [WIDTH-1:0]  diff_full;

  generate
    for (genvar j = 0; j < NUM_HI; j++) begin : g_sel
      localparam int unsigned K   = PIPE_CUT + 1 + j;
      localparam int unsigned OFF = BLOCKS[K-1] - CUT_BIT;
      localparam int unsigned W   = BLOCKS[K] - BLOCKS[K-1];
      logic sel_c;

      if (j == 0) begin : g_first
        assign sel_c = s1_cut_c_q;
      end else begin : g_next
        assign sel_c = hi_cy[j-1];
      end

      assign hi_cy[j]          = sel_c ? s1_c1_q[j] : s1_c0_q[j];
      assign hi_diff[OFF+:W]   = sel_c ? s1_sum1_q[OFF+:W] : s1_sum0_q[OFF+:W];
    end
  endgenerate

  assign diff_full = {hi_diff, s1_lo_q};

  // ---------------------------------------------------------------------------
  // Handshake and next-state
  // ---------------------------------------------------------------------------
  logic s2_adv;
  logic s1_adv;
  logic accept;
  logic s2_load;

  always_comb begin
    s2_adv      = ~out_valid_q | out_ready;
    s1_adv      = ~s1_v_q | s2_adv;
    accept      = in_valid & s1_adv;
    s2_load     = s2_adv & s1_v_q;

    s1_v_d      = s1_v_q;
    s1_lo_d     = s1_lo_q;
    s1_cut_c_d  = s1_cut_c_q;
    s1_sum0_d   = s1_sum0_q;
    s1_sum1_d   = s1_sum1_q;
    s1_c0_d     = s1_c0_q;
    s1_c1_d     = s1_c1_q;
    s1_a_msb_d  = s1_a_msb_q;
    s1_b_msb_d  = s1_b_msb_q;
    out_valid_d = out_valid_q;
    d_d         = d_q;
    bout_d      = bout_q;
    v_d         = v_q;
    z_d         = z_q;

    if (s1_adv) begin
      s1_v_d = accept;
    end
    if (accept) begin
      s1_lo_d    = lo_diff;
      s1_cut_c_d = cy_lo[PIPE_CUT];
      s1_sum0_d  = hi_sum0;
      s1_sum1_d  = hi_sum1;
      s1_c0_d    = hi_c0;
      s1_c1_d    = hi_c1;
      s1_a_msb_d = A[WIDTH-1];
      s1_b_msb_d = B[WIDTH-1];
    end

    if (s2_adv) begin
      out_valid_d = s1_v_q;
    end
    // Result registers only move when a real stage-1 entry advances
    if (s2_load) begin
      d_d    = diff_full;
      bout_d = ~hi_cy[NUM_HI-1];
      v_d    = (s1_a_msb_q ^ s1_b_msb_q) & (s1_a_msb_q ^ diff_full[WIDTH-1]);
      z_d    = ~|diff_full;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q      <= 1'b0;
      s1_lo_q     <= '0;
      s1_cut_c_q  <= 1'b0;
      s1_sum0_q   <= '0;
      s1_sum1_q   <= '0;
      s1_c0_q     <= '0;
      s1_c1_q     <= '0;
      s1_a_msb_q  <= 1'b0;
      s1_b_msb_q  <= 1'b0;
      out_valid_q <= 1'b0;
      d_q         <= '0;
      bout_q      <= 1'b0;
      v_q         <= 1'b0;
      z_q         <= 1'b0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_lo_q     <= s1_lo_d;
      s1_cut_c_q  <= s1_cut_c_d;
      s1_sum0_q   <= s1_sum0_d;
      s1_sum1_q   <= s1_sum1_d;
      s1_c0_q     <= s1_c0_d;
      s1_c1_q     <= s1_c1_d;
      s1_a_msb_q  <= s1_a_msb_d;
      s1_b_msb_q  <= s1_b_msb_d;
      out_valid_q <= out_valid_d;
      d_q         <= d_d;
      bout_q      <= bout_d;
      v_q         <= v_d;
      z_q         <= z_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = out_valid_q;
  assign D         = d_q;
  assign Bout      = bout_q;
  assign V         = v_q;
  assign Z         = z_q;

endmodule

// File: tb/tb_carry_select_subtractor_pipelined_32bits.sv
// Bench for the pipelined subtractor: directed corners, back-pressure, reset flush and random
// streaming, all checked against a plain-arithmetic reference and an in-order expectation queue.
module tb_carry_select_subtractor_pipelined_32bits;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        Bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] D;
  logic        Bout;
  logic        V;
  logic        Z;

  int n_tests = 0;
  int n_fail  = 0;

  carry_select_subtractor_pipelined_32bits dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .Bout      (Bout),
    .V         (V),
    .Z         (Z)
  );

  always #5 clk = ~clk;

  // Reference: {V, Z, Bout, D} from unsigned and signed integer subtraction
  function automatic logic [34:0] ref_sub(input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic [32:0] full;
    longint      sd;
    logic        v;
    full = {1'b0, a} - {1'b0, b} - 33'(bin);
    sd   = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    v    = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return {v, (full[31:0] == 32'd0), full[32], full[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    A = 32'h0000_0009; B = 32'h0000_0001; Bin = 1'b0;
    tick();
    tick();
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: out_valid=%b expected 0", out_valid); end
    n_tests++;
    if ({V, Z, Bout, D} !== 35'd0) begin
      n_fail++; $display("FAIL reset_outputs: V=%b Z=%b Bout=%b D=%h expected all 0", V, Z, Bout, D);
    end
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: in_ready=%b expected 1", in_ready); end
    begin
      int seen = 0;
      for (int i = 0; i < 4; i++) begin
        tick(); #1;
        if (out_valid !== 1'b0) seen++;
      end
      n_tests++;
      if (seen != 0) begin n_fail++; $display("FAIL reset_no_accept: out_valid high %0d cycles expected 0", seen); end
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [9];
    logic [31:0] vb [9];
    logic        vc [9];
    logic [34:0] e;
    va = '{32'd5, 32'd0, 32'd0, 32'h8000_0000, 32'h1234_5678, 32'h0001_0000, 32'h0100_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    vb = '{32'd3, 32'd1, 32'd0, 32'h0000_0001, 32'h1234_5678, 32'h0000_0001, 32'h0000_0400, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vc = '{1'b0,  1'b0,  1'b1,  1'b0,          1'b0,          1'b0,          1'b0,          1'b1,          1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      e = ref_sub(va[i], vb[i], vc[i]);
      tick();
      A = va[i]; B = vb[i]; Bin = vc[i]; in_valid = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_in_ready: in_ready=%b expected 1", i, in_ready); end
      tick();
      in_valid = 1'b0; A = $urandom; B = $urandom; Bin = 1'($urandom_range(0, 1));
      #1;
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_early: out_valid=%b expected 0 after 1 cycle", i, out_valid); end
      tick();
      #1;
      n_tests++;
      if ({out_valid, V, Z, Bout, D} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL dir%0d_result: valid=%b V=%b Z=%b Bout=%b D=%h expected valid=1 V=%b Z=%b Bout=%b D=%h",
                 i, out_valid, V, Z, Bout, D, e[34], e[33], e[32], e[31:0]);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [34:0] exp_q [$];
    logic [34:0] e;
    logic [34:0] held = '0;
    logic        stalled = 1'b0;
    logic        saw_block = 1'b0;
    logic        exp_rdy;
    int          sent = 0;
    int          got = 0;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      tick();
      in_valid  = (sent < 8);
      A = $urandom; B = $urandom; Bin = 1'($urandom_range(0, 1));
      out_ready = !(cyc >= 3 && cyc <= 6);
      #1;
      if (stalled) begin
        n_tests++;
        if ({out_valid, V, Z, Bout, D} !== {1'b1, held}) begin
          n_fail++; $display("FAIL bp_hold: valid=%b D=%h expected valid=1 D=%h", out_valid, D, held[31:0]);
        end
      end
      exp_rdy = ((sent - got) < 2) || out_ready;
      n_tests++;
      if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL bp_in_ready: in_ready=%b expected %b at cycle %0d", in_ready, exp_rdy, cyc); end
      if (in_ready === 1'b0) saw_block = 1'b1;
      if (in_valid && in_ready) begin exp_q.push_back(ref_sub(A, B, Bin)); sent++; end
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bp_spurious: unexpected result D=%h", D);
        end else begin
          e = exp_q.pop_front();
          if ({V, Z, Bout, D} !== e) begin
            n_fail++; $display("FAIL bp_data: result %0d D=%h Bout=%b expected D=%h Bout=%b", got, D, Bout, e[31:0], e[32]);
          end
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      held    = {V, Z, Bout, D};
    end
    in_valid = 1'b0;
    n_tests++;
    if (got != 8) begin n_fail++; $display("FAIL bp_count: got %0d results expected 8", got); end
    n_tests++;
    if (!saw_block) begin n_fail++; $display("FAIL bp_block: in_ready never dropped expected a drop"); end
  endtask

  task automatic test_back_to_back();
    logic [34:0] exp_q [$];
    logic [34:0] e;
    int          sent = 0;
    int          got = 0;
    int          first_acc = -1;
    int          first_out = -1;
    int          last_out = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
      tick();
      in_valid = (sent < 16);
      A = $urandom; B = $urandom; Bin = 1'($urandom_range(0, 1));
      #1;
      if (in_valid && in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        exp_q.push_back(ref_sub(A, B, Bin)); sent++;
      end
      if (out_valid) begin
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        n_tests++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 35'h7_FFFF_FFFF;
        if ({V, Z, Bout, D} !== e) begin
          n_fail++; $display("FAIL b2b_data: result %0d D=%h expected D=%h", got, D, e[31:0]);
        end
        got++;
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (first_out - first_acc != 2) begin n_fail++; $display("FAIL b2b_latency: latency %0d expected 2", first_out - first_acc); end
    n_tests++;
    if (got != 16 || last_out - first_out != 15) begin
      n_fail++; $display("FAIL b2b_rate: %0d results over %0d cycles expected 16 over 16", got, last_out - first_out + 1);
    end
  endtask

  task automatic test_reset_midflight();
    logic [34:0] e;
    int          seen = 0;
    out_ready = 1'b0;
    tick(); in_valid = 1'b1; A = 32'h0000_0064; B = 32'h0000_0001; Bin = 1'b0; #1;
    tick(); in_valid = 1'b1; A = 32'h0000_00C8; B = 32'h0000_0002; Bin = 1'b0; #1;
    tick(); in_valid = 1'b1; A = 32'h0000_0333; B = 32'h0000_0003; rst = 1'b1; #1;
    tick(); in_valid = 1'b0; rst = 1'b0; out_ready = 1'b1; #1;
    n_tests++;
    if ({out_valid, V, Z, Bout, D} !== 36'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: valid=%b V=%b Z=%b Bout=%b D=%h expected all 0", out_valid, V, Z, Bout, D);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: in_ready=%b expected 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      if (out_valid !== 1'b0) seen++;
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL rstmid_stale: out_valid high %0d cycles expected 0", seen); end
    e = ref_sub(32'h0000_1000, 32'h0000_0FFF, 1'b1);
    tick(); in_valid = 1'b1; A = 32'h0000_1000; B = 32'h0000_0FFF; Bin = 1'b1; #1;
    tick(); in_valid = 1'b0; #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_early: out_valid=%b expected 0", out_valid); end
    tick(); #1;
    n_tests++;
    if ({out_valid, V, Z, Bout, D} !== {1'b1, e}) begin
      n_fail++; $display("FAIL rstmid_next: valid=%b D=%h Z=%b expected valid=1 D=%h Z=%b", out_valid, D, Z, e[31:0], e[33]);
    end
    tick();
  endtask

  task automatic test_random();
    localparam int N = 10000;
    logic [34:0] exp_q [$];
    logic [34:0] e;
    logic [34:0] held = '0;
    logic        stalled = 1'b0;
    logic        exp_rdy;
    int          sent = 0;
    int          got = 0;
    for (int cyc = 0; cyc < 60000 && got < N; cyc++) begin
      tick();
      in_valid  = (sent < N) && ($urandom_range(0, 99) < 70);
      A         = $urandom;
      B         = ($urandom_range(0, 7) == 0) ? A : $urandom;
      Bin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 99) < 70);
      #1;
      if (stalled) begin
        n_tests++;
        if ({out_valid, V, Z, Bout, D} !== {1'b1, held}) begin
          n_fail++; $display("FAIL rand_hold: valid=%b D=%h expected valid=1 D=%h", out_valid, D, held[31:0]);
        end
      end
      exp_rdy = ((sent - got) < 2) || out_ready;
      n_tests++;
      if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_in_ready: in_ready=%b expected %b at cycle %0d", in_ready, exp_rdy, cyc); end
      if (in_valid && in_ready) begin exp_q.push_back(ref_sub(A, B, Bin)); sent++; end
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_spurious: unexpected result D=%h", D);
        end else begin
          e = exp_q.pop_front();
          if ({V, Z, Bout, D} !== e) begin
            n_fail++;
            $display("FAIL rand_data: result %0d V=%b Z=%b Bout=%b D=%h expected V=%b Z=%b Bout=%b D=%h",
                     got, V, Z, Bout, D, e[34], e[33], e[32], e[31:0]);
          end
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      held    = {V, Z, Bout, D};
    end
    in_valid = 1'b0;
    n_tests++;
    if (got != N || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rand_count: got %0d results with %0d pending expected %0d and 0", got, exp_q.size(), N);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Bin = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
